mul_arbiter: RTL



---
 rtl/mul_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/mul_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier arbiter: mulsel opcodes, FSM state
// encoding and the opcode legality helper.
package mul_pkg;

    localparam logic [2:0] MUL_OP_NONE   = 3'b000;
    localparam logic [2:0] MUL_OP_MUL    = 3'b001;
    localparam logic [2:0] MUL_OP_MULH   = 3'b010;
    localparam logic [2:0] MUL_OP_MULHSU = 3'b011;
    localparam logic [2:0] MUL_OP_MULHU  = 3'b100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        DRAIN    = 2'd2,
        RESP_ILL = 2'd3
    } mul_arb_state_t;

    // Only the four multiply flavours may reach the multiplier.
    function automatic logic mul_op_legal(input logic [2:0] op);
        logic legal;
        case (op)
            MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: legal = 1'b1;
            default:                                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans the request vector starting at the pointer index
// and returns the first pending requester as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx
);

    logic found;
    int   pos;

    // Rotating priority scan; the first hit from the pointer onwards wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end else begin
                pos = pos;
            end
            if (en && !found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos[IDXW-1:0];
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one 32-bit multiplier between NREQ requesters: round-robin grant,
// operand capture, issue / wait-ready / drain handshake and a one-cycle
// response pulse to the winner.
// Optional feature: define MUL_ARB_WATCHDOG_EN to bound the time spent in
// ISSUE to WDOG_LIMIT cycles; a timeout answers with data 0 and rsp_err = 1.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int WDOG_LIMIT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [3*NREQ-1:0]  req_op,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_data,
    output logic               rsp_err,
    output logic [2:0]         mul_sel,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    input  logic               mul_ready,
    input  logic [31:0]        mul_res
);

    localparam int IDXW = (NREQ > 2) ? 2 : 1;

    if (NREQ < 2 || NREQ > 4 || WDOG_LIMIT < 1) begin : g_bad_param
        $error("mul_arbiter: NREQ must be 2..4 and WDOG_LIMIT at least 1");
    end

    mul_arb_state_t  state_r, state_s;
    logic [IDXW-1:0] ptr_r, gidx_r, gidx_s, ptr_next_s;
    logic [NREQ-1:0] grant_s, rsp_valid_r, gidx_onehot_s;
    logic [2:0]      mul_sel_r, sel_op_s;
    logic [31:0]     a_r, b_r, sel_a_s, sel_b_s, rsp_data_r;
    logic            arb_en_s, any_grant_s, timeout_s;

    logic [2:0]      op_arr_s [NREQ];
    logic [31:0]     a_arr_s  [NREQ];
    logic [31:0]     b_arr_s  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr_s[g] = req_op[3*g +: 3];
        assign a_arr_s[g]  = req_a[32*g +: 32];
        assign b_arr_s[g]  = req_b[32*g +: 32];
    end

    // Grants only happen in IDLE; reset also masks req_ready so a requester
    // never mistakes a held-in-reset cycle for an accept.
    assign arb_en_s = (state_r == IDLE) && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_r),
        .en    (arb_en_s),
        .grant (grant_s),
        .idx   (gidx_s)
    );

    assign any_grant_s   = |grant_s;
    assign sel_op_s      = op_arr_s[gidx_s];
    assign sel_a_s       = a_arr_s[gidx_s];
    assign sel_b_s       = b_arr_s[gidx_s];
    assign ptr_next_s    = (int'(gidx_s) == NREQ - 1) ? '0 : gidx_s + IDXW'(1);
    assign gidx_onehot_s = NREQ'(1) << gidx_r;

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign mul_sel   = mul_sel_r;
    assign mul_a     = a_r;
    assign mul_b     = b_r;

`ifdef MUL_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_LIMIT + 1);

    logic [WDW-1:0] wdog_cnt_r;
    logic           rsp_err_r;

    // Count cycles spent in ISSUE; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_r <= '0;
        end else if (state_r == ISSUE) begin
            wdog_cnt_r <= wdog_cnt_r + WDW'(1);
        end else begin
            wdog_cnt_r <= '0;
        end
    end

    assign timeout_s = (state_r == ISSUE) && !mul_ready &&
                       (wdog_cnt_r == WDW'(WDOG_LIMIT - 1));

    // Error flag rides alongside the timeout response pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_r <= 1'b0;
        end else begin
            rsp_err_r <= timeout_s;
        end
    end

    assign rsp_err = rsp_err_r;
`else
    assign timeout_s = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: grant -> ISSUE/RESP_ILL, result or timeout -> DRAIN,
    // multiplier back to not-ready -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_grant_s) begin
                    if (mul_op_legal(sel_op_s)) begin
                        state_s = ISSUE;
                    end else begin
                        state_s = RESP_ILL;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (mul_ready || timeout_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (!mul_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            RESP_ILL: state_s = IDLE;
            default:  state_s = IDLE;
        endcase
    end

    // Operand/grant capture, multiplier drive and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r       <= '0;
            gidx_r      <= '0;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            mul_sel_r   <= MUL_OP_NONE;
            rsp_valid_r <= '0;
            rsp_data_r  <= 32'd0;
        end else begin
            rsp_valid_r <= '0;
            rsp_data_r  <= 32'd0;
            case (state_r)
                IDLE: begin
                    if (any_grant_s) begin
                        ptr_r  <= ptr_next_s;
                        gidx_r <= gidx_s;
                        a_r    <= sel_a_s;
                        b_r    <= sel_b_s;
                        if (mul_op_legal(sel_op_s)) begin
                            mul_sel_r <= sel_op_s;
                        end else begin
                            // Illegal code: answer next cycle, multiplier stays idle.
                            rsp_valid_r <= grant_s;
                        end
                    end
                end
                ISSUE: begin
                    if (mul_ready) begin
                        rsp_valid_r <= gidx_onehot_s;
                        rsp_data_r  <= mul_res;
                        mul_sel_r   <= MUL_OP_NONE;
                    end else if (timeout_s) begin
                        rsp_valid_r <= gidx_onehot_s;
                        mul_sel_r   <= MUL_OP_NONE;
                    end
                end
                default: begin
                    mul_sel_r <= MUL_OP_NONE;
                end
            endcase
        end
    end

endmodule
